// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to TX_ADDR queue bytes that go out LSB-first as 8N1 frames on tx.
// Optional build macro PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000_0104,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Sel,
  output logic        tx,
  output logic        busy,
  output logic [2:0]  dbgState
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE   = BAUD_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [2:0]        state;
  logic [BAUD_W-1:0] baudCnt;
  logic [2:0]        bitCnt;
  logic [7:0]        shiftReg;
`ifdef PARITY_EN
  logic              parityBit;
`endif

  logic txHit, statusHit, fifoEmpty, fifoFull;
  logic pushReq, pushOk, pop, ovfSet, ovfClr, baudDone;
  logic unusedBits;

  assign txHit     = (DataAdr == TX_ADDR);
  assign statusHit = (DataAdr == STATUS_ADDR);
  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == FULL_COUNT);

  // Push handshake: MemWrite at TX_ADDR is the valid; the FIFO is always ready and
  // accepts unless full, except that a full FIFO popping on the same edge still accepts.
  // A refused byte is dropped and recorded in the sticky overflow bit.
  assign pushReq  = MemWrite && txHit;
  assign pop      = (state == IDLE) && !fifoEmpty;
  assign pushOk   = pushReq && (!fifoFull || pop);
  assign ovfSet   = pushReq && fifoFull && !pop;
  assign ovfClr   = MemWrite && statusHit && WriteData[3];
  assign baudDone = (baudCnt == BAUD_LAST);

  assign busy       = (state != IDLE);
  assign dbgState   = state;
  assign Sel        = txHit || statusHit;
  assign ReadData   = statusHit ? {28'b0, overflow, fifoFull, fifoEmpty, busy} : 32'b0;
  assign unusedBits = ^WriteData[31:8];

  // Storage needs no reset: the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtr] <= WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_ONE;
      if (pop)    rdPtr <= rdPtr + PTR_ONE;
      case ({pushOk, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (ovfSet)      overflow <= 1'b1;
      else if (ovfClr) overflow <= 1'b0;
    end
  end

  // tx is loaded on the same edge that changes state, so the line level always matches the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
`ifdef PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          baudCnt <= '0;
          bitCnt  <= '0;
          if (pop) begin
            shiftReg <= fifoMem[rdPtr];
`ifdef PARITY_EN
            parityBit <= ^fifoMem[rdPtr];
`endif
            state    <= START;
            tx       <= 1'b0;
          end else begin
            tx <= 1'b1;
          end
        end
        START: begin
          if (baudDone) begin
            baudCnt <= '0;
            state   <= DATA;
            tx      <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (baudDone) begin
            baudCnt <= '0;
            if (bitCnt == 3'd7) begin
              bitCnt <= '0;
`ifdef PARITY_EN
              state  <= PARITY;
              tx     <= parityBit;
`else
              state  <= STOP;
              tx     <= 1'b1;
`endif
            end else begin
              bitCnt   <= bitCnt + 3'd1;
              shiftReg <= shiftReg >> 1;
              tx       <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + BAUD_ONE;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (baudDone) begin
            baudCnt <= '0;
            state   <= STOP;
            tx      <= 1'b1;
          end else begin
            baudCnt <= baudCnt + BAUD_ONE;
          end
        end
`endif
        STOP: begin
          if (baudDone) begin
            baudCnt <= '0;
            state   <= IDLE;
            tx      <= 1'b1;
          end else begin
            baudCnt <= baudCnt + BAUD_ONE;
          end
        end
        default: begin
          baudCnt <= '0;
          state   <= IDLE;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule
